attack_table_arbiter: RTL

Round-robin scheduler that shares one AttackTable instance among N envelope-generator requesters. It accepts one 22-bit attack-phase address per enabled cycle and drives the table's address input from a register. It tracks requester ownership through the table's two-stage pipeline and returns each 13-bit shaped result to its requester on a one-hot response strobe. It sits between the per-slot envelope logic and the single shared AttackTable.

---
 rtl/attack_table_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/attack_table_arbiter.sv
// attack_table_arbiter: round-robin share of one AttackTable among N
// envelope requesters, with owner tags tracked through the table pipeline.
module attack_table_arbiter #(
  parameter int N  = 4,
  parameter int AW = 22,
  parameter int DW = 13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clkena,
  input  logic [N-1:0]    req_valid,
  input  logic [N*AW-1:0] req_addr,
  output logic [N-1:0]    req_ready,
  output logic [AW-1:0]   tbl_addr,
  input  logic [DW-1:0]   tbl_data,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic          gnt_any;
  logic [AW-1:0] sel_addr;

  logic          s0_vld, s1_vld, s2_vld;
  logic [PW-1:0] s0_tag, s1_tag, s2_tag;
  logic [N-1:0]  s2_oh;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    req_ready = '0;
    gidx      = '0;
    gnt_any   = 1'b0;
    sel_addr  = '0;
    for (int k = 0; k < N; k++) begin
      if (clkena && !gnt_any && req_valid[nxt(rr_ptr, k)]) begin
        gnt_any = 1'b1;
        gidx    = nxt(rr_ptr, k);
      end
    end
    if (gnt_any) req_ready[gidx] = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (gidx == PW'(k)) sel_addr = req_addr[k*AW +: AW];
    end
  end

  assign s2_oh = {{(N-1){1'b0}}, 1'b1} << s2_tag;
  assign busy  = s0_vld | s1_vld | s2_vld;

  // s1/s2 mirror the table's address-sample and data-register stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      tbl_addr  <= '0;
      s0_vld    <= 1'b0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s0_tag    <= '0;
      s1_tag    <= '0;
      s2_tag    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (clkena) begin
      if (gnt_any) begin
        tbl_addr <= sel_addr;
        s0_vld   <= 1'b1;
        s0_tag   <= gidx;
        rr_ptr   <= nxt(gidx, 1);
      end else begin
        s0_vld   <= 1'b0;
      end
      s1_vld    <= s0_vld;
      s1_tag    <= s0_tag;
      s2_vld    <= s1_vld;
      s2_tag    <= s1_tag;
      rsp_data  <= tbl_data;
      rsp_valid <= s2_vld ? s2_oh : '0;
    end
  end

endmodule
